// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// Optional perf counters are enabled by defining PIPE_PERF_CNT_EN.
package pipeline_ctrl_pkg;

    typedef enum logic {
        StRun     = 1'b0,
        StMemWait = 1'b1
    } state_e;

    // Listed highest priority first; exactly one is selected per cycle.
    typedef enum logic [2:0] {
        CondFreeze  = 3'd0,
        CondBranch  = 3'd1,
        CondLoadUse = 3'd2,
        CondJump    = 3'd3,
        CondNormal  = 3'd4
    } cond_e;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
    localparam int unsigned MemTimeoutDefault = 255;

endpackage

// File: rtl/pipeline_perf_cnt.sv
// Three saturating event counters: load-use stalls, redirect flushes, memory-wait cycles.
// Instantiated only when PIPE_PERF_CNT_EN is defined.
module pipeline_perf_cnt #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             stall_i,
    input  logic             flush_i,
    input  logic             memwait_i,
    output logic [CNT_W-1:0] stall_cycles_o,
    output logic [CNT_W-1:0] flush_events_o,
    output logic [CNT_W-1:0] memwait_cycles_o
);

    logic [CNT_W-1:0] stall_q, stall_d;
    logic [CNT_W-1:0] flush_q, flush_d;
    logic [CNT_W-1:0] memwait_q, memwait_d;

    always_comb begin
        stall_d   = stall_q;
        flush_d   = flush_q;
        memwait_d = memwait_q;
        if (stall_i && (stall_q != '1)) stall_d = stall_q + 1'b1;
        if (flush_i && (flush_q != '1)) flush_d = flush_q + 1'b1;
        if (memwait_i && (memwait_q != '1)) memwait_d = memwait_q + 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            stall_q   <= '0;
            flush_q   <= '0;
            memwait_q <= '0;
        end else begin
            stall_q   <= stall_d;
            flush_q   <= flush_d;
            memwait_q <= memwait_d;
        end
    end

    assign stall_cycles_o   = stall_q;
    assign flush_events_o   = flush_q;
    assign memwait_cycles_o = memwait_q;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hold/flush and PC redirect control for a 5-stage pipeline with a variable-latency data memory.
// Define PIPE_PERF_CNT_EN to add the stall/flush/memwait performance counters.
module pipeline_hazard_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = MemTimeoutDefault
`ifdef PIPE_PERF_CNT_EN
    ,
    parameter int unsigned CNT_W = 32
`endif
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic [4:0]  id_rs_i,
    input  logic [4:0]  id_rt_i,
    input  logic        id_uses_rt_i,
    input  logic        id_jump_i,
    input  logic [31:0] id_jump_target_i,
    input  logic        ex_mem_read_i,
    input  logic [4:0]  ex_reg_dest_i,
    input  logic        ex_branch_taken_i,
    input  logic [31:0] ex_branch_target_i,
    input  logic        mem_req_i,
    input  logic        mem_ready_i,
    output logic        pc_we_o,
    output logic        pc_sel_redirect_o,
    output logic [31:0] pc_redirect_tgt_o,
    output logic        ifid_hold_o,
    output logic        idex_hold_o,
    output logic        exmem_hold_o,
    output logic        memwb_hold_o,
    output logic        ifid_flush_o,
    output logic        idex_flush_o,
    output logic        mem_err_o
`ifdef PIPE_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] stall_cycles_o,
    output logic [CNT_W-1:0] flush_events_o,
    output logic [CNT_W-1:0] memwait_cycles_o
`endif
);

    localparam int unsigned TmoW = (MEM_TIMEOUT > 255) ? $clog2(MEM_TIMEOUT + 1) : 8;
    localparam logic [TmoW-1:0] TmoLast = TmoW'(MEM_TIMEOUT - 1);

    state_e          state_q, state_d;
    logic [TmoW-1:0] tmo_q, tmo_d, tmo_base;
    logic            mem_err_q, mem_err_d;
    logic            freeze, load_use;
    cond_e           cond;

    assign freeze   = mem_req_i && !mem_ready_i;
    assign load_use = ex_mem_read_i && (ex_reg_dest_i != 5'd0) &&
                      ((ex_reg_dest_i == id_rs_i) || (id_uses_rt_i && (ex_reg_dest_i == id_rt_i)));

    always_comb begin
        if (freeze)                 cond = CondFreeze;
        else if (ex_branch_taken_i) cond = CondBranch;
        else if (load_use)          cond = CondLoadUse;
        else if (id_jump_i)         cond = CondJump;
        else                        cond = CondNormal;
    end

    // The first freeze cycle counts too, so mem_err sets after exactly MEM_TIMEOUT stalled cycles.
    assign tmo_base = (state_q == StMemWait) ? tmo_q : '0;

    always_comb begin
        state_d   = state_q;
        tmo_d     = tmo_q;
        mem_err_d = mem_err_q;
        if (freeze) begin
            state_d = StMemWait;
            if (tmo_base != '1) tmo_d = tmo_base + 1'b1;
            if ((MEM_TIMEOUT != 0) && (tmo_base == TmoLast)) mem_err_d = 1'b1;
        end else begin
            state_d = StRun;
            tmo_d   = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q   <= StRun;
            tmo_q     <= '0;
            mem_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            tmo_q     <= tmo_d;
            mem_err_q <= mem_err_d;
        end
    end

    always_comb begin
        pc_we_o           = 1'b0;
        pc_sel_redirect_o = 1'b0;
        pc_redirect_tgt_o = 32'h0;
        ifid_hold_o       = 1'b0;
        idex_hold_o       = 1'b0;
        exmem_hold_o      = 1'b0;
        memwb_hold_o      = 1'b0;
        ifid_flush_o      = 1'b0;
        idex_flush_o      = 1'b0;
        if (reset_i) begin
            ifid_flush_o = 1'b1;
            idex_flush_o = 1'b1;
        end else begin
            unique case (cond)
                CondFreeze: begin
                    ifid_hold_o  = 1'b1;
                    idex_hold_o  = 1'b1;
                    exmem_hold_o = 1'b1;
                    memwb_hold_o = 1'b1;
                end
                CondBranch: begin
                    pc_we_o           = 1'b1;
                    pc_sel_redirect_o = 1'b1;
                    pc_redirect_tgt_o = ex_branch_target_i;
                    ifid_flush_o      = 1'b1;
                    idex_flush_o      = 1'b1;
                end
                CondLoadUse: begin
                    ifid_hold_o  = 1'b1;
                    idex_flush_o = 1'b1;
                end
                CondJump: begin
                    pc_we_o           = 1'b1;
                    pc_sel_redirect_o = 1'b1;
                    pc_redirect_tgt_o = id_jump_target_i;
                    ifid_flush_o      = 1'b1;
                end
                default: pc_we_o = 1'b1;
            endcase
        end
    end

    assign mem_err_o = mem_err_q;

`ifdef PIPE_PERF_CNT_EN
    pipeline_perf_cnt #(
        .CNT_W (CNT_W)
    ) u_perf_cnt (
        .clk_i            (clk_i),
        .reset_i          (reset_i),
        .stall_i          (!reset_i && (cond == CondLoadUse)),
        .flush_i          (!reset_i && ((cond == CondBranch) || (cond == CondJump))),
        .memwait_i        (!reset_i && (cond == CondFreeze)),
        .stall_cycles_o   (stall_cycles_o),
        .flush_events_o   (flush_events_o),
        .memwait_cycles_o (memwait_cycles_o)
    );
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl; inputs change 1ns after posedge, outputs checked mid-cycle.
module tb_pipeline_hazard_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  id_rs, id_rt, ex_reg_dest;
    logic        id_uses_rt, id_jump, ex_mem_read, ex_branch_taken, mem_req, mem_ready;
    logic [31:0] id_jump_target, ex_branch_target;
    logic        pc_we, pc_sel, ifid_hold, idex_hold, exmem_hold, memwb_hold;
    logic        ifid_flush, idex_flush, mem_err;
    logic [31:0] pc_tgt;
`ifdef PIPE_PERF_CNT_EN
    logic [31:0] stall_cycles, flush_events, memwait_cycles;
`endif

    int n_vec = 0;
    int n_err = 0;

    // {pc_we, redirect, ifid_h, idex_h, exmem_h, memwb_h, ifid_f, idex_f, mem_err}
    localparam logic [8:0] RST     = 9'b00_0000_11_0;
    localparam logic [8:0] NORMAL  = 9'b10_0000_00_0;
    localparam logic [8:0] LOADUSE = 9'b00_1000_01_0;
    localparam logic [8:0] BRANCH  = 9'b11_0000_11_0;
    localparam logic [8:0] JUMP    = 9'b11_0000_10_0;
    localparam logic [8:0] FREEZE  = 9'b00_1111_00_0;
    localparam logic [8:0] ERR     = 9'b00_0000_00_1;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(
        .MEM_TIMEOUT (4)
    ) dut (
        .clk_i              (clk),
        .reset_i            (reset),
        .id_rs_i            (id_rs),
        .id_rt_i            (id_rt),
        .id_uses_rt_i       (id_uses_rt),
        .id_jump_i          (id_jump),
        .id_jump_target_i   (id_jump_target),
        .ex_mem_read_i      (ex_mem_read),
        .ex_reg_dest_i      (ex_reg_dest),
        .ex_branch_taken_i  (ex_branch_taken),
        .ex_branch_target_i (ex_branch_target),
        .mem_req_i          (mem_req),
        .mem_ready_i        (mem_ready),
        .pc_we_o            (pc_we),
        .pc_sel_redirect_o  (pc_sel),
        .pc_redirect_tgt_o  (pc_tgt),
        .ifid_hold_o        (ifid_hold),
        .idex_hold_o        (idex_hold),
        .exmem_hold_o       (exmem_hold),
        .memwb_hold_o       (memwb_hold),
        .ifid_flush_o       (ifid_flush),
        .idex_flush_o       (idex_flush),
        .mem_err_o          (mem_err)
`ifdef PIPE_PERF_CNT_EN
        ,
        .stall_cycles_o     (stall_cycles),
        .flush_events_o     (flush_events),
        .memwait_cycles_o   (memwait_cycles)
`endif
    );

    task automatic idle_inputs();
        id_rs = 5'd0; id_rt = 5'd0; id_uses_rt = 1'b0; id_jump = 1'b0;
        id_jump_target = 32'h0; ex_mem_read = 1'b0; ex_reg_dest = 5'd0;
        ex_branch_taken = 1'b0; ex_branch_target = 32'h0; mem_req = 1'b0; mem_ready = 1'b0;
    endtask

    task automatic chk(input string tag, input logic [8:0] exp_ctl, input logic [31:0] exp_tgt);
        logic [8:0] ctl;
        #3;
        ctl = {pc_we, pc_sel, ifid_hold, idex_hold, exmem_hold, memwb_hold,
               ifid_flush, idex_flush, mem_err};
        n_vec++;
        assert (ctl === exp_ctl) else begin
            n_err++;
            $error("FAIL %s ctl observed %b expected %b", tag, ctl, exp_ctl);
        end
        n_vec++;
        assert (pc_tgt === exp_tgt) else begin
            n_err++;
            $error("FAIL %s tgt observed %h expected %h", tag, pc_tgt, exp_tgt);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        idle_inputs();
        reset = 1'b1;
        chk("reset", RST, 32'h0);
        tick();
        reset = 1'b0;
        chk("idle", NORMAL, 32'h0);
        tick();

        // Load-use on rs: one bubble, then normal once the load has moved to MEM.
        ex_mem_read = 1'b1; ex_reg_dest = 5'd5; id_rs = 5'd5;
        chk("lu_rs", LOADUSE, 32'h0);
        tick();
        ex_mem_read = 1'b0;
        chk("lu_after", NORMAL, 32'h0);
        tick();

        ex_mem_read = 1'b1; ex_reg_dest = 5'd7; id_rs = 5'd1; id_rt = 5'd7; id_uses_rt = 1'b1;
        chk("lu_rt", LOADUSE, 32'h0);
        tick();
        id_uses_rt = 1'b0;
        chk("rt_unused", NORMAL, 32'h0);
        tick();

        ex_reg_dest = 5'd0; id_rs = 5'd0; id_rt = 5'd0;
        chk("r0_no_stall", NORMAL, 32'h0);
        tick();

        // Branch beats a coincident load-use and jump.
        ex_reg_dest = 5'd5; id_rs = 5'd5; id_jump = 1'b1; id_jump_target = 32'h0000_0080;
        ex_branch_taken = 1'b1; ex_branch_target = 32'h0000_0040;
        chk("branch_prio", BRANCH, 32'h0000_0040);
        tick();
        idle_inputs();
        id_jump = 1'b1; id_jump_target = 32'h0000_0080;
        chk("jump", JUMP, 32'h0000_0080);
        tick();
        mem_req = 1'b1; mem_ready = 1'b1;
        chk("mem_ready_now", JUMP, 32'h0000_0080);
        tick();

        // Freeze 3 cycles with a pending taken branch; the branch fires on release.
        idle_inputs();
        mem_req = 1'b1; ex_branch_taken = 1'b1; ex_branch_target = 32'h0000_0040;
        for (int i = 0; i < 3; i++) begin
            chk("freeze_br", FREEZE, 32'h0);
            tick();
        end
        mem_ready = 1'b1;
        chk("release_br", BRANCH, 32'h0000_0040);
        tick();
        idle_inputs();
        chk("post_release", NORMAL, 32'h0);
`ifdef PIPE_PERF_CNT_EN
        n_vec++;
        assert (stall_cycles === 32'd2) else begin
            n_err++; $error("FAIL perf_stall observed %0d expected 2", stall_cycles);
        end
        n_vec++;
        assert (flush_events === 32'd4) else begin
            n_err++; $error("FAIL perf_flush observed %0d expected 4", flush_events);
        end
        n_vec++;
        assert (memwait_cycles === 32'd3) else begin
            n_err++; $error("FAIL perf_memwait observed %0d expected 3", memwait_cycles);
        end
`endif
        tick();

        // Timeout with MEM_TIMEOUT=4: mem_err visible from the 5th stalled cycle.
        mem_req = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("tmo_wait", FREEZE, 32'h0);
            tick();
        end
        chk("tmo_err", FREEZE | ERR, 32'h0);
        tick();
        reset = 1'b1;
        chk("tmo_reset", RST | ERR, 32'h0);
        tick();
        reset = 1'b0; mem_req = 1'b0;
        chk("err_cleared", NORMAL, 32'h0);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
